// File: rtl/sbus_mem_seq_if.sv
// Request-side and SBUS-side signals of the MBOX memory request sequencer.
// The slave view belongs to the sequencer; the master view drives it.
interface sbus_mem_seq_if;
   logic        rq_valid;
   logic        rq_ready;
   logic        rq_write;
   logic        rq_chan;
   logic [21:0] rq_adr;
   logic [3:0]  rq_mask;
   logic        mem_start_a;
   logic        mem_start_b;
   logic        mem_rd_rq;
   logic        mem_wr_rq;
   logic [21:0] mem_adr;
   logic [3:0]  mem_wd_rq;
   logic        sbus_ackn;
   logic        sbus_data_valid;
   logic [35:0] sbus_data;
   logic        sbus_par;
   logic        ackn_pulse;
   logic        core_busy;
   logic        core_rd_in_prog;
   logic        rd_word_valid;
   logic [1:0]  rd_word_sel;
   logic [35:0] rd_word;
   logic        rd_nxm_data;
   logic        rd_par_err;
   logic        nxm_err;
   logic        dv_timeout_err;
   logic        err_clr;

   modport slave (
      input  rq_valid, rq_write, rq_chan, rq_adr, rq_mask,
      input  sbus_ackn, sbus_data_valid, sbus_data, sbus_par, err_clr,
      output rq_ready, mem_start_a, mem_start_b, mem_rd_rq, mem_wr_rq,
      output mem_adr, mem_wd_rq, ackn_pulse, core_busy, core_rd_in_prog,
      output rd_word_valid, rd_word_sel, rd_word, rd_nxm_data, rd_par_err,
      output nxm_err, dv_timeout_err
   );

   modport master (
      output rq_valid, rq_write, rq_chan, rq_adr, rq_mask,
      output sbus_ackn, sbus_data_valid, sbus_data, sbus_par, err_clr,
      input  rq_ready, mem_start_a, mem_start_b, mem_rd_rq, mem_wr_rq,
      input  mem_adr, mem_wd_rq, ackn_pulse, core_busy, core_rd_in_prog,
      input  rd_word_valid, rd_word_sel, rd_word, rd_nxm_data, rd_par_err,
      input  nxm_err, dv_timeout_err
   );
endinterface

// File: rtl/sbus_mem_seq.sv
// SBUS memory request sequencer: issues START A/B, runs the ACKN and DATA VALID
// handshake, orders returned quad words and synthesizes NXM / timeout fill words.
module sbus_mem_seq #(
   parameter int NXM_LIMIT = 32,
   parameter int DV_LIMIT  = 64
) (
   input  logic           clk,
   input  logic           RESET,
   sbus_mem_seq_if.slave  bus
);

   localparam int MAX_LIMIT = (NXM_LIMIT > DV_LIMIT) ? NXM_LIMIT : DV_LIMIT;
   localparam int CW        = $clog2(MAX_LIMIT);
   localparam logic [CW-1:0] NXM_LAST = CW'(NXM_LIMIT - 1);
   localparam logic [CW-1:0] DV_LAST  = CW'(DV_LIMIT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      START    = 2'd1,
      RD_WAIT  = 2'd2,
      NXM_FILL = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        write_q, write_d;
   logic        chan_q, chan_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [3:0]  rem_q, rem_d;
   logic        start_a_q, start_a_d;
   logic        start_b_q, start_b_d;
   logic        rd_rq_q, rd_rq_d;
   logic        wr_rq_q, wr_rq_d;
   logic [21:0] adr_q, adr_d;
   logic [3:0]  wd_q, wd_d;
   logic        ackn_q, ackn_d;
   logic        busy_q, busy_d;
   logic        in_prog_q, in_prog_d;
   logic        word_valid_q, word_valid_d;
   logic [1:0]  word_sel_q, word_sel_d;
   logic [35:0] word_q, word_d;
   logic        nxm_data_q, nxm_data_d;
   logic        par_err_q, par_err_d;
   logic        nxm_err_q, nxm_err_d;
   logic        dv_err_q, dv_err_d;

   logic [1:0]  cur_sel;
   logic [3:0]  rem_after;
   logic        deliver;
   logic        fill;

   // Next word to deliver: first still-pending mask bit at or after the pointer, mod 4.
   always_comb begin
      cur_sel = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         if (rem_q[ptr_q + 2'(k)]) cur_sel = ptr_q + 2'(k);
      end
      rem_after = rem_q & ~(4'b0001 << cur_sel);
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      write_d      = write_q;
      chan_d       = chan_q;
      ptr_d        = ptr_q;
      rem_d        = rem_q;
      adr_d        = adr_q;
      wd_d         = wd_q;
      start_a_d    = 1'b0;
      start_b_d    = 1'b0;
      rd_rq_d      = 1'b0;
      wr_rq_d      = 1'b0;
      ackn_d       = 1'b0;
      word_valid_d = 1'b0;
      word_sel_d   = 2'd0;
      word_d       = 36'd0;
      nxm_data_d   = 1'b0;
      par_err_d    = 1'b0;
      nxm_err_d    = nxm_err_q & ~bus.err_clr;
      dv_err_d     = dv_err_q & ~bus.err_clr;
      deliver      = 1'b0;
      fill         = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.rq_valid) begin
               write_d = bus.rq_write;
               chan_d  = bus.rq_chan;
               adr_d   = bus.rq_adr;
               wd_d    = bus.rq_mask;
               rem_d   = bus.rq_mask;
               ptr_d   = bus.rq_adr[1:0];
               if (bus.rq_mask != 4'd0) begin
                  state_d   = START;
                  cnt_d     = '0;
                  start_a_d = ~bus.rq_chan;
                  start_b_d = bus.rq_chan;
                  rd_rq_d   = ~bus.rq_write;
                  wr_rq_d   = bus.rq_write;
               end
            end
         end
         START: begin
            // A real ACKN on the limit cycle takes priority over declaring NXM.
            if (bus.sbus_ackn) begin
               ackn_d  = 1'b1;
               cnt_d   = '0;
               state_d = write_q ? IDLE : RD_WAIT;
            end else if (cnt_q == NXM_LAST) begin
               ackn_d    = 1'b1;
               nxm_err_d = 1'b1;
               state_d   = write_q ? IDLE : NXM_FILL;
            end else begin
               cnt_d     = cnt_q + CW'(1);
               start_a_d = ~chan_q;
               start_b_d = chan_q;
               rd_rq_d   = ~write_q;
               wr_rq_d   = write_q;
            end
         end
         RD_WAIT: begin
            if (bus.sbus_data_valid) begin
               deliver = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q == DV_LAST) begin
               dv_err_d = 1'b1;
               state_d  = NXM_FILL;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         NXM_FILL: begin
            deliver = 1'b1;
            fill    = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (deliver) begin
         word_valid_d = 1'b1;
         word_sel_d   = cur_sel;
         word_d       = fill ? 36'd0 : bus.sbus_data;
         nxm_data_d   = fill;
         par_err_d    = fill ? 1'b0 : ~^{bus.sbus_data, bus.sbus_par};
         rem_d        = rem_after;
         ptr_d        = cur_sel + 2'd1;
         if (rem_after == 4'd0) state_d = IDLE;
      end

      busy_d    = (state_d != IDLE);
      in_prog_d = (state_d == RD_WAIT) || (state_d == NXM_FILL);
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         write_q      <= 1'b0;
         chan_q       <= 1'b0;
         ptr_q        <= 2'd0;
         rem_q        <= 4'd0;
         adr_q        <= 22'd0;
         wd_q         <= 4'd0;
         start_a_q    <= 1'b0;
         start_b_q    <= 1'b0;
         rd_rq_q      <= 1'b0;
         wr_rq_q      <= 1'b0;
         ackn_q       <= 1'b0;
         busy_q       <= 1'b0;
         in_prog_q    <= 1'b0;
         word_valid_q <= 1'b0;
         word_sel_q   <= 2'd0;
         word_q       <= 36'd0;
         nxm_data_q   <= 1'b0;
         par_err_q    <= 1'b0;
         nxm_err_q    <= 1'b0;
         dv_err_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         write_q      <= write_d;
         chan_q       <= chan_d;
         ptr_q        <= ptr_d;
         rem_q        <= rem_d;
         adr_q        <= adr_d;
         wd_q         <= wd_d;
         start_a_q    <= start_a_d;
         start_b_q    <= start_b_d;
         rd_rq_q      <= rd_rq_d;
         wr_rq_q      <= wr_rq_d;
         ackn_q       <= ackn_d;
         busy_q       <= busy_d;
         in_prog_q    <= in_prog_d;
         word_valid_q <= word_valid_d;
         word_sel_q   <= word_sel_d;
         word_q       <= word_d;
         nxm_data_q   <= nxm_data_d;
         par_err_q    <= par_err_d;
         nxm_err_q    <= nxm_err_d;
         dv_err_q     <= dv_err_d;
      end
   end

   assign bus.rq_ready        = (state_q == IDLE) && !RESET;
   assign bus.mem_start_a     = start_a_q;
   assign bus.mem_start_b     = start_b_q;
   assign bus.mem_rd_rq       = rd_rq_q;
   assign bus.mem_wr_rq       = wr_rq_q;
   assign bus.mem_adr         = adr_q;
   assign bus.mem_wd_rq       = wd_q;
   assign bus.ackn_pulse      = ackn_q;
   assign bus.core_busy       = busy_q;
   assign bus.core_rd_in_prog = in_prog_q;
   assign bus.rd_word_valid   = word_valid_q;
   assign bus.rd_word_sel     = word_sel_q;
   assign bus.rd_word         = word_q;
   assign bus.rd_nxm_data     = nxm_data_q;
   assign bus.rd_par_err      = par_err_q;
   assign bus.nxm_err         = nxm_err_q;
   assign bus.dv_timeout_err  = dv_err_q;

endmodule

// File: tb/tb_sbus_mem_seq.sv
// Directed bench for sbus_mem_seq: read ordering, writes, NXM, DATA VALID timeout,
// mid-read reset, no-op mask and the ACKN / DATA VALID limit-cycle boundaries.
module tb_sbus_mem_seq;

   localparam int NXM = 8;
   localparam int DV  = 12;

   logic clk = 1'b0;
   logic RESET;
   int   n_compared   = 0;
   int   n_mismatched = 0;

   logic [35:0] rd_data [4];
   logic [1:0]  rd_sel_exp [4];
   logic [35:0] d;

   sbus_mem_seq_if bus();

   sbus_mem_seq #(.NXM_LIMIT(NXM), .DV_LIMIT(DV)) dut (
      .clk   (clk),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // Present one request for a single accepting edge, then withdraw it.
   task automatic applyStimulus(input logic wr, input logic ch, input logic [21:0] adr, input logic [3:0] mask);
      bus.rq_valid = 1'b1;
      bus.rq_write = wr;
      bus.rq_chan  = ch;
      bus.rq_adr   = adr;
      bus.rq_mask  = mask;
      stepClock();
      bus.rq_valid = 1'b0;
   endtask

   function automatic logic oddPar(input logic [35:0] v);
      return ~(^v);
   endfunction

   initial begin
      RESET               = 1'b1;
      bus.rq_valid        = 1'b0;
      bus.rq_write        = 1'b0;
      bus.rq_chan         = 1'b0;
      bus.rq_adr          = 22'd0;
      bus.rq_mask         = 4'd0;
      bus.sbus_ackn       = 1'b0;
      bus.sbus_data_valid = 1'b0;
      bus.sbus_data       = 36'd0;
      bus.sbus_par        = 1'b0;
      bus.err_clr         = 1'b0;
      rd_data    = '{36'h111111111, 36'h2468ACE03, 36'h0F0F0F0F0, 36'h800000001};
      rd_sel_exp = '{2'd2, 2'd3, 2'd0, 2'd1};

      repeat (2) stepClock();
      checkOutput("rst_rq_ready", bus.rq_ready, 0);
      checkOutput("rst_busy", bus.core_busy, 0);
      checkOutput("rst_start_a", bus.mem_start_a, 0);
      checkOutput("rst_ackn", bus.ackn_pulse, 0);
      checkOutput("rst_nxm_err", bus.nxm_err, 0);
      RESET = 1'b0;
      #1;
      checkOutput("idle_rq_ready", bus.rq_ready, 1);

      // Read, start index 2, full mask, ACKN on the third edge after start.
      applyStimulus(1'b0, 1'b0, 22'h12346, 4'b1111);
      checkOutput("t1_start_a", bus.mem_start_a, 1);
      checkOutput("t1_start_b", bus.mem_start_b, 0);
      checkOutput("t1_rd_rq", bus.mem_rd_rq, 1);
      checkOutput("t1_adr", bus.mem_adr, 22'h12346);
      checkOutput("t1_wd", bus.mem_wd_rq, 4'hF);
      checkOutput("t1_busy", bus.core_busy, 1);
      checkOutput("t1_ready_busy", bus.rq_ready, 0);
      repeat (2) stepClock();
      checkOutput("t1_start_held", bus.mem_start_a, 1);
      checkOutput("t1_no_ackn", bus.ackn_pulse, 0);
      bus.sbus_ackn = 1'b1;
      stepClock();
      bus.sbus_ackn = 1'b0;
      checkOutput("t1_ackn", bus.ackn_pulse, 1);
      checkOutput("t1_start_drop", bus.mem_start_a, 0);
      checkOutput("t1_rd_rq_drop", bus.mem_rd_rq, 0);
      checkOutput("t1_in_prog", bus.core_rd_in_prog, 1);
      stepClock();
      checkOutput("t1_ackn_once", bus.ackn_pulse, 0);
      for (int i = 0; i < 4; i++) begin
         bus.sbus_data_valid = 1'b1;
         bus.sbus_data       = rd_data[i];
         bus.sbus_par        = oddPar(rd_data[i]);
         stepClock();
         checkOutput("t1_wvalid", bus.rd_word_valid, 1);
         checkOutput("t1_sel", bus.rd_word_sel, rd_sel_exp[i]);
         checkOutput("t1_word", bus.rd_word, rd_data[i]);
         checkOutput("t1_par_ok", bus.rd_par_err, 0);
         checkOutput("t1_not_nxm", bus.rd_nxm_data, 0);
         checkOutput("t1_in_prog_w", bus.core_rd_in_prog, (i < 3) ? 1 : 0);
      end
      bus.sbus_data_valid = 1'b0;
      checkOutput("t1_busy_end", bus.core_busy, 0);
      stepClock();
      checkOutput("t1_wvalid_end", bus.rd_word_valid, 0);

      // Write on channel, START B held until ACKN; DATA VALID must be ignored.
      applyStimulus(1'b1, 1'b1, 22'h01000, 4'b0101);
      checkOutput("t2_start_b", bus.mem_start_b, 1);
      checkOutput("t2_start_a", bus.mem_start_a, 0);
      checkOutput("t2_wr_rq", bus.mem_wr_rq, 1);
      checkOutput("t2_rd_rq", bus.mem_rd_rq, 0);
      checkOutput("t2_wd", bus.mem_wd_rq, 4'b0101);
      bus.sbus_data_valid = 1'b1;
      repeat (2) stepClock();
      checkOutput("t2_start_held", bus.mem_start_b, 1);
      checkOutput("t2_no_word", bus.rd_word_valid, 0);
      bus.sbus_ackn = 1'b1;
      stepClock();
      bus.sbus_ackn = 1'b0;
      checkOutput("t2_ackn", bus.ackn_pulse, 1);
      checkOutput("t2_start_drop", bus.mem_start_b, 0);
      stepClock();
      bus.sbus_data_valid = 1'b0;
      checkOutput("t2_busy_after", bus.core_busy, 0);
      checkOutput("t2_ackn_once", bus.ackn_pulse, 0);
      checkOutput("t2_no_word_end", bus.rd_word_valid, 0);
      checkOutput("t2_ready", bus.rq_ready, 1);

      // Read with no ACKN: NXM at NXM cycles after start, fill words 1 then 3.
      applyStimulus(1'b0, 1'b0, 22'h00100, 4'b1010);
      repeat (NXM - 1) stepClock();
      checkOutput("t3_pre_ackn", bus.ackn_pulse, 0);
      checkOutput("t3_pre_nxm", bus.nxm_err, 0);
      checkOutput("t3_pre_start", bus.mem_start_a, 1);
      stepClock();
      checkOutput("t3_ackn", bus.ackn_pulse, 1);
      checkOutput("t3_nxm", bus.nxm_err, 1);
      checkOutput("t3_start_drop", bus.mem_start_a, 0);
      checkOutput("t3_in_prog", bus.core_rd_in_prog, 1);
      stepClock();
      checkOutput("t3_w0_valid", bus.rd_word_valid, 1);
      checkOutput("t3_w0_sel", bus.rd_word_sel, 1);
      checkOutput("t3_w0_word", bus.rd_word, 0);
      checkOutput("t3_w0_nxm", bus.rd_nxm_data, 1);
      checkOutput("t3_w0_par", bus.rd_par_err, 0);
      stepClock();
      checkOutput("t3_w1_valid", bus.rd_word_valid, 1);
      checkOutput("t3_w1_sel", bus.rd_word_sel, 3);
      checkOutput("t3_w1_nxm", bus.rd_nxm_data, 1);
      checkOutput("t3_in_prog_end", bus.core_rd_in_prog, 0);
      stepClock();
      checkOutput("t3_no_more", bus.rd_word_valid, 0);
      checkOutput("t3_nxm_sticky", bus.nxm_err, 1);
      bus.err_clr = 1'b1;
      stepClock();
      bus.err_clr = 1'b0;
      checkOutput("t3_nxm_clr", bus.nxm_err, 0);

      // Read words 0,1: word 0 has bad parity, word 1 times out and is filled.
      applyStimulus(1'b0, 1'b0, 22'h00200, 4'b0011);
      bus.sbus_ackn = 1'b1;
      stepClock();
      bus.sbus_ackn = 1'b0;
      checkOutput("t4_ackn", bus.ackn_pulse, 1);
      d = 36'h0000000F1;
      bus.sbus_data_valid = 1'b1;
      bus.sbus_data       = d;
      bus.sbus_par        = ^d;
      stepClock();
      bus.sbus_data_valid = 1'b0;
      checkOutput("t4_w0_sel", bus.rd_word_sel, 0);
      checkOutput("t4_w0_word", bus.rd_word, 36'h0000000F1);
      checkOutput("t4_w0_par_err", bus.rd_par_err, 1);
      repeat (DV - 1) stepClock();
      checkOutput("t4_pre_dv_err", bus.dv_timeout_err, 0);
      checkOutput("t4_pre_in_prog", bus.core_rd_in_prog, 1);
      stepClock();
      checkOutput("t4_dv_err", bus.dv_timeout_err, 1);
      checkOutput("t4_no_word_yet", bus.rd_word_valid, 0);
      stepClock();
      checkOutput("t4_w1_valid", bus.rd_word_valid, 1);
      checkOutput("t4_w1_sel", bus.rd_word_sel, 1);
      checkOutput("t4_w1_nxm", bus.rd_nxm_data, 1);
      checkOutput("t4_w1_par", bus.rd_par_err, 0);
      checkOutput("t4_w1_word", bus.rd_word, 0);
      checkOutput("t4_in_prog_end", bus.core_rd_in_prog, 0);
      checkOutput("t4_nxm_clear", bus.nxm_err, 0);
      bus.err_clr = 1'b1;
      stepClock();
      bus.err_clr = 1'b0;
      checkOutput("t4_dv_clr", bus.dv_timeout_err, 0);

      // Reset after the first of four words abandons the read.
      applyStimulus(1'b0, 1'b0, 22'h3FFFFC, 4'b1111);
      bus.sbus_ackn = 1'b1;
      stepClock();
      bus.sbus_ackn = 1'b0;
      d = 36'h5A5A5A5A5;
      bus.sbus_data_valid = 1'b1;
      bus.sbus_data       = d;
      bus.sbus_par        = oddPar(d);
      stepClock();
      bus.sbus_data_valid = 1'b0;
      checkOutput("t5_w0_valid", bus.rd_word_valid, 1);
      RESET = 1'b1;
      #1;
      checkOutput("t5_ready_rst", bus.rq_ready, 0);
      stepClock();
      checkOutput("t5_busy", bus.core_busy, 0);
      checkOutput("t5_in_prog", bus.core_rd_in_prog, 0);
      checkOutput("t5_wvalid", bus.rd_word_valid, 0);
      checkOutput("t5_word", bus.rd_word, 0);
      checkOutput("t5_adr", bus.mem_adr, 0);
      checkOutput("t5_wd", bus.mem_wd_rq, 0);
      checkOutput("t5_rd_rq", bus.mem_rd_rq, 0);
      RESET = 1'b0;
      bus.sbus_data_valid = 1'b1;
      stepClock();
      bus.sbus_data_valid = 1'b0;
      checkOutput("t5_dv_ignored", bus.rd_word_valid, 0);
      checkOutput("t5_busy_after", bus.core_busy, 0);

      // Zero mask: accepted, no SBUS cycle.
      applyStimulus(1'b0, 1'b0, 22'h00004, 4'b0000);
      checkOutput("t6_no_start", bus.mem_start_a, 0);
      checkOutput("t6_no_busy", bus.core_busy, 0);
      checkOutput("t6_ready", bus.rq_ready, 1);
      stepClock();
      checkOutput("t6_no_ackn", bus.ackn_pulse, 0);

      // ACKN on the NXM limit cycle, then DATA VALID on the DV limit cycle.
      applyStimulus(1'b0, 1'b0, 22'h00003, 4'b0001);
      repeat (NXM - 1) stepClock();
      bus.sbus_ackn = 1'b1;
      stepClock();
      bus.sbus_ackn = 1'b0;
      checkOutput("t7_ackn", bus.ackn_pulse, 1);
      checkOutput("t7_no_nxm", bus.nxm_err, 0);
      checkOutput("t7_in_prog", bus.core_rd_in_prog, 1);
      checkOutput("t7_nxm_fill", bus.rd_word_valid, 0);
      repeat (DV - 1) stepClock();
      checkOutput("t7_pre_dv", bus.dv_timeout_err, 0);
      d = 36'hCAFE01234;
      bus.sbus_data_valid = 1'b1;
      bus.sbus_data       = d;
      bus.sbus_par        = oddPar(d);
      stepClock();
      bus.sbus_data_valid = 1'b0;
      checkOutput("t7_wvalid", bus.rd_word_valid, 1);
      checkOutput("t7_sel", bus.rd_word_sel, 0);
      checkOutput("t7_word", bus.rd_word, 36'hCAFE01234);
      checkOutput("t7_not_nxm", bus.rd_nxm_data, 0);
      checkOutput("t7_no_dv_err", bus.dv_timeout_err, 0);
      checkOutput("t7_in_prog_end", bus.core_rd_in_prog, 0);
      stepClock();
      checkOutput("t7_dv_err_after", bus.dv_timeout_err, 0);
      checkOutput("t7_nxm_after", bus.nxm_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
